fx2_stream_writer: RTL and testbench

- Downstream stage of the ADC capture path.
- Takes I/Q sample pairs (14-bit, from D_A/D_B capture), sign-extends them to 16-bit words and buffers them in a small internal FIFO.
- Drains the FIFO into the FX2 slave FIFO (synchronous mode, EP6 IN) by driving FD, SLWR, FIFOADR, SLOE and PKTEND.
- Sits between the ADC capture register and the FX2 pins in main; runs entirely on the IFCLK-domain clock.

---
 rtl/fx2_stream_writer_pkg.sv | 23 ++
 rtl/fx2_stream_writer_if.sv | 33 +++
 rtl/fx2_stream_writer_fifo.sv | 53 +++++
 rtl/fx2_stream_writer.sv | 150 +++++++++++++++
 tb/tb_fx2_stream_writer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fx2_stream_writer_pkg.sv
// Shared FX2 definitions: writer states, endpoint FIFOADR codes, bus/ADC widths
// and the ADC-to-bus sign extension helper.
package fx2_pkg;

    localparam int FX2_WIDTH = 16;
    localparam int ADC_WIDTH = 14;

    localparam logic [1:0] EP2_ADDR = 2'b00;
    localparam logic [1:0] EP4_ADDR = 2'b01;
    localparam logic [1:0] EP6_ADDR = 2'b10;
    localparam logic [1:0] EP8_ADDR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        PKTEND
    } fx2_state_t;

    function automatic logic [FX2_WIDTH-1:0] sext_adc(input logic [ADC_WIDTH-1:0] s);
        return {{(FX2_WIDTH - ADC_WIDTH){s[ADC_WIDTH-1]}}, s};
    endfunction

endpackage

// File: rtl/fx2_stream_writer_if.sv
// FX2 slave-FIFO pin bundle; master is the FPGA writer, slave is the FX2 side.
interface fx2_stream_writer_if;
    import fx2_pkg::*;

    logic [FX2_WIDTH-1:0] fd_out;
    logic                 fd_oe;
    logic                 fx2_slwr_n;
    logic                 fx2_sloe_n;
    logic [1:0]           fx2_fifoadr;
    logic                 fx2_pktend_n;
    logic                 fx2_full_n;

    modport master (
        output fd_out,
        output fd_oe,
        output fx2_slwr_n,
        output fx2_sloe_n,
        output fx2_fifoadr,
        output fx2_pktend_n,
        input  fx2_full_n
    );

    modport slave (
        input  fd_out,
        input  fd_oe,
        input  fx2_slwr_n,
        input  fx2_sloe_n,
        input  fx2_fifoadr,
        input  fx2_pktend_n,
        output fx2_full_n
    );

endinterface

// File: rtl/fx2_stream_writer_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; the head word is visible
// combinationally. Callers never push when full or pop when empty.
module sync_fifo_fwft #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fx2_stream_writer.sv
// Packs 14-bit I/Q pairs into 16-bit words and streams them into the FX2 EP6
// slave FIFO. Define FX2_PKTEND_TIMEOUT_EN to commit short packets after idling.
module fx2_stream_writer
    import fx2_pkg::*;
#(
    parameter int         DEPTH_LOG2  = 4,
    parameter int         PKT_WORDS   = 256,
    parameter logic [1:0] EP_ADDR     = EP6_ADDR,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  smp_valid,
    input  logic [ADC_WIDTH-1:0]  smp_i,
    input  logic [ADC_WIDTH-1:0]  smp_q,
    fx2_stream_writer_if.master   fx2,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   fill_level
);

    localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PAIR_ROOM = (DEPTH_LOG2 + 1)'(DEPTH - 2);
    localparam int                  WC_W      = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [WC_W-1:0]     WC_LAST   = WC_W'(PKT_WORDS - 1);

    fx2_state_t           state;
    logic                 fd_oe_q;
    logic [WC_W-1:0]      word_cnt;
    logic                 prev_valid;
    logic                 q_pending;
    logic [FX2_WIDTH-1:0] q_stage;
    logic [FX2_WIDTH-1:0] push_data;
    logic [FX2_WIDTH-1:0] head;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    // A pair is only taken when both words fit now; Q follows one cycle later.
    assign accept    = smp_valid && !prev_valid && (fill_level <= PAIR_ROOM);
    assign push      = accept || q_pending;
    assign push_data = q_pending ? q_stage : sext_adc(smp_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            q_pending  <= 1'b0;
            q_stage    <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_valid <= smp_valid;
            q_pending  <= accept;
            if (accept) begin
                q_stage <= sext_adc(smp_q);
            end
            if (smp_valid && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH      (FX2_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fill_level)
    );

    // The strobe is gated by rst so a reset never leaves a half-finished handshake.
    assign pop = (state == WRITE) && !fifo_empty && fx2.fx2_full_n && !rst;

    assign fx2.fd_out      = fd_oe_q ? head : '0;
    assign fx2.fd_oe       = fd_oe_q;
    assign fx2.fx2_slwr_n  = !pop;
    assign fx2.fx2_sloe_n  = 1'b1;
    assign fx2.fx2_fifoadr = EP_ADDR;

`ifdef FX2_PKTEND_TIMEOUT_EN
    localparam int             TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

    logic             pktend_q;
    logic [TMO_W-1:0] tmo_cnt;

    assign fx2.fx2_pktend_n = pktend_q;
`else
    assign fx2.fx2_pktend_n = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fd_oe_q  <= 1'b0;
            word_cnt <= '0;
`ifdef FX2_PKTEND_TIMEOUT_EN
            pktend_q <= 1'b1;
            tmo_cnt  <= '0;
`endif
        end else begin
            // Full packets are committed by the FX2 itself, so the counter just wraps.
            if (pop) begin
                word_cnt <= (word_cnt == WC_LAST) ? '0 : word_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty && fx2.fx2_full_n) begin
                        state   <= WRITE;
                        fd_oe_q <= 1'b1;
                    end
`ifdef FX2_PKTEND_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LIMIT && fx2.fx2_full_n) begin
                        state    <= PKTEND;
                        pktend_q <= 1'b0;
                    end
`endif
                end
                WRITE: begin
                    if (fifo_empty) begin
                        state   <= IDLE;
                        fd_oe_q <= 1'b0;
                    end
                end
`ifdef FX2_PKTEND_TIMEOUT_EN
                PKTEND: begin
                    state    <= IDLE;
                    pktend_q <= 1'b1;
                    word_cnt <= '0;
                end
`endif
                default: state <= IDLE;
            endcase
`ifdef FX2_PKTEND_TIMEOUT_EN
            // Saturates at the limit so a commit blocked by full_n is not lost.
            if (state != IDLE || word_cnt == '0) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_LIMIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fx2_stream_writer.sv
// Scoreboard bench for fx2_stream_writer: a pair-level reference model queues the
// expected FD words and a negedge monitor checks every SLWR strobe against it.
module tb_fx2_stream_writer;
    import fx2_pkg::*;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;

    logic                clk;
    logic                rst;
    logic                smp_valid;
    logic [13:0]         smp_i;
    logic [13:0]         smp_q;
    logic                overflow;
    logic [DEPTH_LOG2:0] fill_level;

    fx2_stream_writer_if bus ();

    fx2_stream_writer #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .PKT_WORDS   (256),
        .EP_ADDR     (EP6_ADDR),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .smp_valid  (smp_valid),
        .smp_i      (smp_i),
        .smp_q      (smp_q),
        .fx2        (bus),
        .overflow   (overflow),
        .fill_level (fill_level)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    int          write_cycles[$];
    int          accepted_total = 0;
    int          written_total = 0;
    int          last_strobe_cyc = -10;
    bit          model_ovf = 0;
    bit          toggling;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required end before time 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Two's-complement value of the 14-bit sample re-encoded on 16 bits.
    function automatic logic [15:0] ref_word(input logic [13:0] v);
        int value;
        value = (v >= 14'd8192) ? int'(v) - 16384 : int'(v);
        return 16'(value);
    endfunction

    // Monitor: every write strobe pops one expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check_output("pktend_n_high", bus.fx2_pktend_n, 1);
                check_output("sloe_n_high", bus.fx2_sloe_n, 1);
                if (bus.fx2_slwr_n == 1'b0) begin
                    written_total++;
                    write_cycles.push_back(cyc);
                    check_output("write_only_when_not_full", bus.fx2_full_n, 1);
                    check_output("fd_oe_during_write", bus.fd_oe, 1);
                    check_output("fifoadr_during_write", bus.fx2_fifoadr, EP6_ADDR);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_write: got word %0h, expected no write", bus.fd_out);
                    end else begin
                        check_output("fd_word", bus.fd_out, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle strobe; the model decides acceptance from the pair rules.
    task automatic apply_stimulus(input logic [13:0] i, input logic [13:0] q);
        if (last_strobe_cyc == cyc - 1) begin
            model_ovf = 1;
        end else if (accepted_total - written_total + 2 <= DEPTH) begin
            exp_q.push_back(ref_word(i));
            exp_q.push_back(ref_word(q));
            accepted_total += 2;
        end else begin
            model_ovf = 1;
        end
        last_strobe_cyc = cyc;
        smp_valid = 1'b1;
        smp_i = i;
        smp_q = q;
        @(posedge clk);
        #1;
        smp_valid = 1'b0;
        smp_i = 14'($urandom);
        smp_q = 14'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        accepted_total = 0;
        written_total = 0;
        last_strobe_cyc = -10;
        model_ovf = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(3);
        @(negedge clk);
        check_output("drain_words_left", exp_q.size(), 0);
        check_output("drain_fill_level", fill_level, 0);
        check_output("drain_fd_oe", bus.fd_oe, 0);
        check_output("overflow_vs_model", overflow, model_ovf);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int push_cyc;
        rst = 1'b1;
        smp_valid = 1'b0;
        smp_i = '0;
        smp_q = '0;
        bus.fx2_full_n = 1'b1;
        idle(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_output("rst_fd_out", bus.fd_out, 0);
        check_output("rst_fd_oe", bus.fd_oe, 0);
        check_output("rst_slwr_n", bus.fx2_slwr_n, 1);
        check_output("rst_sloe_n", bus.fx2_sloe_n, 1);
        check_output("rst_fifoadr", bus.fx2_fifoadr, EP6_ADDR);
        check_output("rst_pktend_n", bus.fx2_pktend_n, 1);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_fill_level", fill_level, 0);
        @(posedge clk);
        #1;

        // Single pair, latency and sign extension
        write_cycles.delete();
        push_cyc = cyc;
        apply_stimulus(14'h3F31, 14'h0005);
        wait_drain(20);
        check_output("single_write_count", write_cycles.size(), 2);
        check_output("first_write_latency", (write_cycles.size() > 0) ? write_cycles[0] : -1, push_cyc + 2);
        check_output("second_write_cycle", (write_cycles.size() > 1) ? write_cycles[1] : -1, push_cyc + 3);

        // Full stall with three pairs
        bus.fx2_full_n = 1'b0;
        write_cycles.delete();
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(14'($urandom), 14'($urandom));
            idle(1);
        end
        @(negedge clk);
        check_output("stall_fill_level", fill_level, 6);
        check_output("stall_no_writes", write_cycles.size(), 0);
        @(posedge clk);
        #1;
        bus.fx2_full_n = 1'b1;
        wait_drain(40);
        check_output("stall_release_writes", write_cycles.size(), 6);

        // Overflow: fill to the brim, drop a whole pair
        bus.fx2_full_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(14'($urandom), 14'($urandom));
            idle(1);
        end
        @(negedge clk);
        check_output("full_fill_level", fill_level, 16);
        check_output("full_no_overflow", overflow, 0);
        @(posedge clk);
        #1;
        apply_stimulus(14'h1234, 14'h2345);
        idle(1);
        @(negedge clk);
        check_output("drop_fill_level", fill_level, 16);
        check_output("drop_overflow", overflow, model_ovf);
        @(posedge clk);
        #1;
        idle(4);
        @(negedge clk);
        check_output("overflow_sticky", overflow, 1);
        @(posedge clk);
        #1;

        // Reset mid-burst
        bus.fx2_full_n = 1'b1;
        idle(3);
        do_reset();
        @(negedge clk);
        check_output("midrst_slwr_n", bus.fx2_slwr_n, 1);
        check_output("midrst_fd_oe", bus.fd_oe, 0);
        check_output("midrst_fill_level", fill_level, 0);
        check_output("midrst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        idle(4);

        // Back-to-back strobes: second one ignored
        write_cycles.delete();
        apply_stimulus(14'h2001, 14'h1FFE);
        apply_stimulus(14'h0AAA, 14'h1555);
        wait_drain(20);
        check_output("consecutive_writes", write_cycles.size(), 2);
        check_output("consecutive_overflow", overflow, 1);

        // 256-word burst with full_n toggling every cycle
        do_reset();
        write_cycles.delete();
        toggling = 1;
        fork
            begin
                while (toggling) begin
                    bus.fx2_full_n = ~bus.fx2_full_n;
                    @(posedge clk);
                    #1;
                end
            end
            begin
                for (int k = 0; k < 128; k++) begin
                    apply_stimulus(14'($urandom), 14'($urandom));
                    idle(4);
                end
                wait_drain(400);
                toggling = 0;
            end
        join
        bus.fx2_full_n = 1'b1;
        check_output("burst_write_count", write_cycles.size(), 256);

        // Randomised gaps and full_n, including illegal back-to-back strobes
        do_reset();
        toggling = 1;
        fork
            begin
                while (toggling) begin
                    bus.fx2_full_n = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    apply_stimulus(14'($urandom), 14'($urandom));
                    idle($urandom_range(0, 3));
                end
                toggling = 0;
            end
        join
        bus.fx2_full_n = 1'b1;
        wait_drain(200);

        // Idle after a short write: no PKTEND in the default build
        apply_stimulus(14'h0001, 14'h3FFF);
        wait_drain(20);
        idle(40);
        @(negedge clk);
        check_output("no_pktend_after_idle", bus.fx2_pktend_n, 1);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
